// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU and response signals of the issue controller
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_out;
  logic        alu_error;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_error;
  logic        out_halt;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        halted;
  modport master (
    output in_valid, in_opcode, in_a, in_b, alu_out, alu_error, out_ready,
    input  in_ready, alu_opcode, alu_in1, alu_in2, out_valid, out_data, out_error, out_halt,
           flag_n, flag_z, flag_v, halted
  );
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, alu_out, alu_error, out_ready,
    output in_ready, alu_opcode, alu_in1, alu_in2, out_valid, out_data, out_error, out_halt,
           flag_n, flag_z, flag_v, halted
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one instruction at a time through the ALU and owns the N/Z/V flags
module alu_issue_ctrl (
  input logic clk,
  input logic rst,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP, HALT} state_t;
  state_t state_q, state_d;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q, data_q, res;
  logic        err_q, halt_q, n_q, z_q, v_q, err, uses_alu, upd_nv, upd_z;
  // state register
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  // next state; HLT skips EXEC and parks in HALT once its marker is consumed
  always_comb begin
    state_d = state_q == IDLE ? (bus.in_valid ? (bus.in_opcode == 4'hF ? RESP : EXEC) : IDLE) :
              state_q == EXEC ? RESP :
              state_q == RESP ? (bus.out_ready ? (halt_q ? HALT : IDLE) : RESP) : HALT;
  end
  // ALU drive and handshake outputs; ALU is only driven in EXEC for ALU and LW/SW opcodes
  always_comb begin
    uses_alu       = state_q == EXEC && op_q <= 4'd9;
    bus.alu_opcode = uses_alu && !op_q[3] ? op_q : 4'd0;
    bus.alu_in1    = uses_alu ? (op_q[3] ? a_q & 16'hFFFE : a_q) : 16'd0;
    bus.alu_in2    = uses_alu ? (op_q[3] ? {b_q[14:0], 1'b0} : b_q) : 16'd0;
    bus.in_ready   = state_q == IDLE;
    bus.out_valid  = state_q == RESP;
    bus.halted     = state_q == HALT;
  end
  // result selection and flag-update classes for the latched opcode
  always_comb begin
    res    = op_q <= 4'd9 ? bus.alu_out :
             op_q == 4'hA ? (a_q & 16'hFF00) | {8'h00, b_q[7:0]} :
             op_q == 4'hB ? (a_q & 16'h00FF) | {b_q[7:0], 8'h00} : a_q;
    err    = (op_q == 4'd0 || op_q == 4'd1 || op_q == 4'd8 || op_q == 4'd9) && bus.alu_error;
    upd_nv = op_q == 4'd0 || op_q == 4'd1;
    upd_z  = upd_nv || op_q == 4'd2 || op_q == 4'd4 || op_q == 4'd5 || op_q == 4'd6;
  end
  // operand latch, held response and architectural flags
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 4'd0;
      a_q    <= 16'd0;
      b_q    <= 16'd0;
      data_q <= 16'd0;
      err_q  <= 1'b0;
      halt_q <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        op_q   <= bus.in_opcode;
        a_q    <= bus.in_a;
        b_q    <= bus.in_b;
        data_q <= 16'd0;
        err_q  <= 1'b0;
        halt_q <= bus.in_opcode == 4'hF;
      end
      if (state_q == EXEC) begin
        data_q <= res;
        err_q  <= err;
        if (upd_nv) begin
          n_q <= res[15];
          v_q <= bus.alu_error;
        end
        if (upd_z) z_q <= res == 16'd0;
      end
    end
  end
  assign bus.out_data  = data_q;
  assign bus.out_error = err_q;
  assign bus.out_halt  = halt_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_v    = v_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench for the ALU issue controller
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  alu_issue_ctrl_if bus ();
  alu_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // behavioural ALU: ADD/SUB with signed overflow, XOR, others return 0
  always_comb begin
    bus.alu_out   = 16'd0;
    bus.alu_error = 1'b0;
    if (bus.alu_opcode == 4'd0) begin
      bus.alu_out   = bus.alu_in1 + bus.alu_in2;
      bus.alu_error = bus.alu_in1[15] == bus.alu_in2[15] && bus.alu_out[15] != bus.alu_in1[15];
    end else if (bus.alu_opcode == 4'd1) begin
      bus.alu_out   = bus.alu_in1 - bus.alu_in2;
      bus.alu_error = bus.alu_in1[15] != bus.alu_in2[15] && bus.alu_out[15] != bus.alu_in1[15];
    end else if (bus.alu_opcode == 4'd2) begin
      bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
    end
  end
  typedef struct {
    logic [15:0] d;
    logic        e;
    logic        h;
    logic [2:0]  f;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  // monitor: compares the held response with the head of the scoreboard every cycle it is presented
  logic pv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = q[0];
        if (!pv) chk("latency", cyc, e.acc + e.lat);
        chk("out_data", bus.out_data, e.d);
        chk("out_error", bus.out_error, e.e);
        chk("out_halt", bus.out_halt, e.h);
        chk("flags_nzv", {bus.flag_n, bus.flag_z, bus.flag_v}, e.f);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
    pv = bus.out_valid;
  end
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] xop, input logic [15:0] x1, input logic [15:0] x2,
                       input logic [15:0] d, input logic e, input logic [2:0] f, input bit keep);
    exp_t x;
    int n = 0;
    step();
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("accept_timeout", 1, 0);
    x.d = d; x.e = e; x.h = op == 4'hF; x.f = f; x.acc = cyc; x.lat = op == 4'hF ? 1 : 2;
    q.push_back(x);
    step();
    chk("alu_opcode", bus.alu_opcode, xop);
    chk("alu_in1", bus.alu_in1, x1);
    chk("alu_in2", bus.alu_in2, x2);
    if (!keep) bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_error", bus.out_error, 0);
    chk("rst_out_halt", bus.out_halt, 0);
    chk("rst_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_alu", {bus.alu_opcode, bus.alu_in1, bus.alu_in2}, 0);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_opcode = 4'd0; bus.in_a = 16'd0; bus.in_b = 16'd0; bus.out_ready = 1'b1;
    repeat (3) step();
    chk_reset_vals();
    rst = 1'b0;
    issue(4'h0, 16'h7FFF, 16'h0001, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1, 3'b101, 0); drain();
    issue(4'h1, 16'h0005, 16'h0005, 4'h1, 16'h0005, 16'h0005, 16'h0000, 0, 3'b010, 0); drain();
    issue(4'h2, 16'h00F0, 16'h00F0, 4'h2, 16'h00F0, 16'h00F0, 16'h0000, 0, 3'b010, 0); drain();
    issue(4'h0, 16'h7FFF, 16'h0001, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1, 3'b101, 0); drain();
    issue(4'h2, 16'h00F0, 16'h000F, 4'h2, 16'h00F0, 16'h000F, 16'h00FF, 0, 3'b101, 0); drain();
    issue(4'h8, 16'h1001, 16'hFFFE, 4'h0, 16'h1000, 16'hFFFC, 16'h0FFC, 0, 3'b101, 0); drain();
    issue(4'h9, 16'h7FFE, 16'h0001, 4'h0, 16'h7FFE, 16'h0002, 16'h8000, 1, 3'b101, 0); drain();
    issue(4'hA, 16'hABCD, 16'h0012, 4'h0, 16'h0000, 16'h0000, 16'hAB12, 0, 3'b101, 0); drain();
    issue(4'hB, 16'hABCD, 16'h0012, 4'h0, 16'h0000, 16'h0000, 16'h12CD, 0, 3'b101, 0); drain();
    issue(4'hC, 16'h1234, 16'h5678, 4'h0, 16'h0000, 16'h0000, 16'h1234, 0, 3'b101, 0); drain();
    bus.out_ready = 1'b0;
    issue(4'h0, 16'h0001, 16'h0002, 4'h0, 16'h0001, 16'h0002, 16'h0003, 0, 3'b000, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    drain();
    issue(4'hF, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 3'b000, 0); drain();
    bus.in_valid = 1'b1;
    bus.in_opcode = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halted", bus.halted, 1);
      chk("halt_in_ready", bus.in_ready, 0);
      chk("halt_out_valid", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk_reset_vals();
    bus.in_valid = 1'b1; bus.in_opcode = 4'h0; bus.in_a = 16'h7FFF; bus.in_b = 16'h0001;
    step();
    chk("mid_exec_alu_in1", bus.alu_in1, 16'h7FFF);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals();
    step();
    chk("after_rst_out_valid", bus.out_valid, 0);
    chk("after_rst_flags", {bus.flag_n, bus.flag_z, bus.flag_v}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing controller that sits between decode and the 16-bit ALU. Accepts one instruction at a time over a valid/ready handshake and drives the ALU opcode and operands, including the address-add path for LW/SW. Computes LLB/LHB locally, captures the ALU result into a held response, and owns the architectural N/Z/V flag register with per-opcode update rules. Enters a sticky halt state on HLT.

## Interface
- No parameters; datapath width fixed at 16, opcode width fixed at 4.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept (IDLE only)
- in_opcode  in  4  ISA opcode, 0000 ADD … 1111 HLT
- in_a  in  16  source operand 1 (Rs)
- in_b  in  16  source operand 2 (Rt, or sign-extended immediate/offset)
- alu_opcode  out  4  opcode driven to ALU
- alu_in1  out  16  ALU operand 1
- alu_in2  out  16  ALU operand 2
- alu_out  in  16  ALU result (combinational from alu_*)
- alu_error  in  1  ALU overflow/error
- out_valid  out  1  response held
- out_ready  in  1  consumer accepts response
- out_data  out  16  result
- out_error  out  1  overflow on ADD/SUB/address add
- out_halt  out  1  response is the HLT marker
- flag_n, flag_z, flag_v  out  1 each  architectural flags
- halted  out  1  controller halted

## Operation
- FSM states: IDLE, EXEC, RESP, HALT.
- IDLE: in_ready=1. On in_valid, latch opcode/a/b into internal registers and go to EXEC. HLT (1111) goes directly to RESP with out_halt=1 and then to HALT.
- EXEC (one cycle): drive alu_* from the latched registers. Capture the result into the out registers, then go to RESP.
  - 0000–0111 (ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB): alu_opcode=latched opcode, alu_in1=a, alu_in2=b. out_data=alu_out. out_error=alu_error for ADD/SUB, else 0.
  - 1000/1001 (LW/SW): alu_opcode=0000, alu_in1=a & 16'hFFFE, alu_in2=b<<1 (drop bit 15). out_data=alu_out. out_error=alu_error.
  - 1010 LLB: out_data=(a & 16'hFF00) | {8'h00,b[7:0]}. The ALU is not used.
  - 1011 LHB: out_data=(a & 16'h00FF) | {b[7:0],8'h00}.
  - 1100/1101/1110 (B/BR/PCS): out_data=a, out_error=0.
- Outside EXEC, alu_opcode/alu_in1/alu_in2 drive 0.
- Flag update, on the EXEC→RESP edge only:
  - ADD/SUB: N=out_data[15], Z=(out_data==0), V=alu_error.
  - XOR/SLL/SRA/ROR: Z only.
  - All other opcodes: no change.
- RESP: out_valid=1. out_data/out_error/out_halt are stable until out_ready. On out_ready, go to IDLE, or to HALT if out_halt.
- HALT: in_ready=0, out_valid=0, halted=1. Only rst exits.
- Reset values: state IDLE, out_valid 0, out_data 0, out_error 0, out_halt 0, flags 0, halted 0, in_ready 1 (IDLE). A reset in any state discards the in-flight op and flags are not updated.

## Timing
- Accept at edge T (in_valid & in_ready), EXEC during T..T+1, out_valid high from T+2.
- HLT: out_valid high from T+1.
- Minimum issue interval is 3 cycles with out_ready tied high.
- The response is held indefinitely while out_ready=0. in_ready stays 0 until the response is consumed.
- Flags become visible the same cycle out_valid rises.
- in_valid in non-IDLE states is ignored and needs no back-pressure beyond in_ready=0.

## Test plan
- Reset then ADD a=16'h7FFF b=16'h0001 -> out_data 16'h8000, out_error 1, N=1 Z=0 V=1 at T+2.
- SUB a=16'h0005 b=16'h0005, then XOR a=16'h00F0 b=16'h00F0 -> both give out_data 0 and Z=1. After XOR, N and V keep the values set by SUB.
- LW a=16'h1001 b=16'hFFFE -> alu_opcode 0000, alu_in1 16'h1000, alu_in2 16'hFFFC, out_data 16'h0FFC. Flags unchanged.
- LLB a=16'hABCD b=16'h0012 -> out_data 16'hAB12. LHB on the same operands -> 16'h12CD. The alu_* ports stay 0 throughout.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> out_* stable, in_ready=0, no second accept. Release out_ready -> IDLE next cycle.
- HLT -> out_halt=1 at T+1. After out_ready, halted=1 and in_ready=0. Assert rst mid-EXEC in a separate run -> all outputs at reset values on the next cycle.
